// File: rtl/exwb_arbiter.sv
// exwb_arbiter: writeback stage behind execute. Completions from the five
// execution units (alu, fwd, jmp, br, mem) are queued per unit and
// round-robin arbitrated onto one registered broadcast bus toward the ROB.
// Jumps and taken branches carry a PC redirect.
// Optional feature macro: EXWB_BYPASS_EN. When it is defined, an empty unit
// whose completion arrives this cycle may win arbitration directly, skipping
// its FIFO.
module exwb_arbiter #(
  parameter int               TAG_W       = 4,
  parameter int               XLEN        = 32,
  parameter int               DEPTH       = 4,
  parameter int               AFULL_TH    = 3,
  parameter logic [TAG_W-1:0] TAG_INVALID = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] alu_target,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [TAG_W-1:0] fwd_target,
  input  logic [XLEN-1:0]  fwd_result,
  input  logic [TAG_W-1:0] jmp_target,
  input  logic [XLEN-1:0]  jmp_ori_pc,
  input  logic [XLEN-1:0]  jmp_next_pc,
  input  logic [TAG_W-1:0] br_target,
  input  logic [XLEN-1:0]  br_next_pc,
  input  logic             br_cmp_res,
  input  logic [TAG_W-1:0] mem_target,
  input  logic [XLEN-1:0]  mem_result,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [XLEN-1:0]  wb_value,
  output logic [2:0]       wb_src,
  output logic             wb_redirect,
  output logic [XLEN-1:0]  wb_redirect_pc,
  output logic [4:0]       afull,
  output logic             overflow
);

  localparam int NSRC  = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  // Incoming completion, normalised into the stored entry format
  logic [TAG_W-1:0] in_tag_s   [NSRC];
  logic [XLEN-1:0]  in_value_s [NSRC];
  logic [XLEN-1:0]  in_rpc_s   [NSRC];
  logic [NSRC-1:0]  in_redir_s;
  logic [NSRC-1:0]  in_valid_s;

  // Per-source FIFO storage and bookkeeping
  logic [TAG_W-1:0] tag_mem_r   [NSRC][DEPTH];
  logic [XLEN-1:0]  value_mem_r [NSRC][DEPTH];
  logic [XLEN-1:0]  rpc_mem_r   [NSRC][DEPTH];
  logic             redir_mem_r [NSRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr_r    [NSRC];
  logic [PTR_W-1:0] rd_ptr_r    [NSRC];
  logic [CNT_W-1:0] count_r     [NSRC];
  logic [2:0]       rr_r;

  logic [NSRC-1:0]  cand_s, push_want_s, full_s, push_s, pop_s, drop_s;
  logic             gnt_valid_s, byp_s;
  logic [2:0]       gnt_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic [XLEN-1:0]  sel_value_s, sel_rpc_s;
  logic             sel_redir_s;

  // Source index reached by stepping off places from base, wrapping 4 -> 0
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NSRC) t = t - NSRC;
    else t = t;
    return 3'(t);
  endfunction

  // Map each unit's ports onto {tag, value, redirect, redirect_pc}
  always_comb begin
    in_tag_s[0] = alu_target; in_value_s[0] = alu_result;
    in_redir_s[0] = 1'b0;     in_rpc_s[0] = '0;
    in_tag_s[1] = fwd_target; in_value_s[1] = fwd_result;
    in_redir_s[1] = 1'b0;     in_rpc_s[1] = '0;
    in_tag_s[2] = jmp_target; in_value_s[2] = jmp_ori_pc + XLEN'(4);
    in_redir_s[2] = 1'b1;     in_rpc_s[2] = jmp_next_pc;
    in_tag_s[3] = br_target;  in_value_s[3] = '0;
    in_redir_s[3] = br_cmp_res; in_rpc_s[3] = br_next_pc;
    in_tag_s[4] = mem_target; in_value_s[4] = mem_result;
    in_redir_s[4] = 1'b0;     in_rpc_s[4] = '0;
    for (int s = 0; s < NSRC; s++) begin
      in_valid_s[s] = (in_tag_s[s] != TAG_INVALID);
    end
  end

  // Round-robin grant: first candidate at or after the pointer
  always_comb begin
    cand_s      = '0;
    gnt_valid_s = 1'b0;
    gnt_s       = 3'd0;
    for (int s = 0; s < NSRC; s++) begin
`ifdef EXWB_BYPASS_EN
      cand_s[s] = (count_r[s] != '0) || in_valid_s[s];
`else
      cand_s[s] = (count_r[s] != '0);
`endif
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!gnt_valid_s && cand_s[rr_index(rr_r, i)]) begin
        gnt_valid_s = 1'b1;
        gnt_s       = rr_index(rr_r, i);
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
`ifdef EXWB_BYPASS_EN
    byp_s = gnt_valid_s && (count_r[gnt_s] == '0);
`else
    byp_s = 1'b0;
`endif
  end

  // Push/pop decisions; a push into a full FIFO survives only alongside a pop
  always_comb begin
    push_want_s = '0;
    full_s      = '0;
    push_s      = '0;
    pop_s       = '0;
    drop_s      = '0;
    for (int s = 0; s < NSRC; s++) begin
      pop_s[s]       = gnt_valid_s && (gnt_s == 3'(s)) && !byp_s;
      push_want_s[s] = in_valid_s[s] && !(byp_s && (gnt_s == 3'(s)));
      full_s[s]      = (count_r[s] == CNT_W'(DEPTH));
      push_s[s]      = push_want_s[s] && (!full_s[s] || pop_s[s]);
      drop_s[s]      = push_want_s[s] && full_s[s] && !pop_s[s];
    end
  end

  // Entry that the granted source delivers to the output register
  always_comb begin
    if (byp_s) begin
      sel_tag_s   = in_tag_s[gnt_s];
      sel_value_s = in_value_s[gnt_s];
      sel_redir_s = in_redir_s[gnt_s];
      sel_rpc_s   = in_rpc_s[gnt_s];
    end else begin
      sel_tag_s   = tag_mem_r[gnt_s][rd_ptr_r[gnt_s]];
      sel_value_s = value_mem_r[gnt_s][rd_ptr_r[gnt_s]];
      sel_redir_s = redir_mem_r[gnt_s][rd_ptr_r[gnt_s]];
      sel_rpc_s   = rpc_mem_r[gnt_s][rd_ptr_r[gnt_s]];
    end
  end

  // Almost-full flags straight from the registered occupancy counts
  always_comb begin
    afull = '0;
    for (int s = 0; s < NSRC; s++) begin
      afull[s] = (count_r[s] >= CNT_W'(AFULL_TH));
    end
  end

  // FIFO payload storage; contents are don't-care while a slot is empty
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (!flush && push_s[s]) begin
        tag_mem_r[s][wr_ptr_r[s]]   <= in_tag_s[s];
        value_mem_r[s][wr_ptr_r[s]] <= in_value_s[s];
        redir_mem_r[s][wr_ptr_r[s]] <= in_redir_s[s];
        rpc_mem_r[s][wr_ptr_r[s]]   <= in_rpc_s[s];
      end
    end
  end

  // FIFO indices, counts, arbitration pointer, sticky overflow and wb register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSRC; s++) begin
        wr_ptr_r[s] <= '0;
        rd_ptr_r[s] <= '0;
        count_r[s]  <= '0;
      end
      rr_r           <= 3'd0;
      overflow       <= 1'b0;
      wb_valid       <= 1'b0;
      wb_tag         <= TAG_INVALID;
      wb_value       <= '0;
      wb_src         <= 3'd0;
      wb_redirect    <= 1'b0;
      wb_redirect_pc <= '0;
    end else if (flush) begin
      for (int s = 0; s < NSRC; s++) begin
        wr_ptr_r[s] <= '0;
        rd_ptr_r[s] <= '0;
        count_r[s]  <= '0;
      end
      rr_r        <= 3'd0;
      wb_valid    <= 1'b0;
      wb_redirect <= 1'b0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (push_s[s]) wr_ptr_r[s] <= wr_ptr_r[s] + PTR_W'(1'b1);
        if (pop_s[s])  rd_ptr_r[s] <= rd_ptr_r[s] + PTR_W'(1'b1);
        count_r[s] <= count_r[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
      end
      overflow <= overflow | (|drop_s);
      if (gnt_valid_s) begin
        wb_valid       <= 1'b1;
        wb_tag         <= sel_tag_s;
        wb_value       <= sel_value_s;
        wb_src         <= gnt_s;
        wb_redirect    <= sel_redir_s;
        wb_redirect_pc <= sel_rpc_s;
        rr_r           <= rr_index(gnt_s, 1);
      end else begin
        wb_valid    <= 1'b0;
        wb_redirect <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exwb_arbiter.sv
// Directed self-checking bench for exwb_arbiter (default parameters).
module tb_exwb_arbiter;

`ifdef EXWB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  alu_target = '0, fwd_target = '0, jmp_target = '0, br_target = '0, mem_target = '0;
  logic [31:0] alu_result = '0, fwd_result = '0, jmp_ori_pc = '0, jmp_next_pc = '0;
  logic [31:0] br_next_pc = '0, mem_result = '0;
  logic        br_cmp_res = 1'b0;
  logic        wb_valid, wb_redirect, overflow;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value, wb_redirect_pc;
  logic [2:0]  wb_src;
  logic [4:0]  afull;

  int tests_run = 0;
  int tests_failed = 0;

  exwb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_target(alu_target), .alu_result(alu_result),
    .fwd_target(fwd_target), .fwd_result(fwd_result),
    .jmp_target(jmp_target), .jmp_ori_pc(jmp_ori_pc), .jmp_next_pc(jmp_next_pc),
    .br_target(br_target), .br_next_pc(br_next_pc), .br_cmp_res(br_cmp_res),
    .mem_target(mem_target), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_src(wb_src),
    .wb_redirect(wb_redirect), .wb_redirect_pc(wb_redirect_pc),
    .afull(afull), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_target = '0; fwd_target = '0; jmp_target = '0; br_target = '0; mem_target = '0;
    br_cmp_res = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b exp 0", wb_valid); end
    tests_run++; if (wb_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_tag: got %0h exp 0", wb_tag); end
    tests_run++; if (wb_value !== 32'd0) begin tests_failed++; $display("FAIL reset_value: got %0h exp 0", wb_value); end
    tests_run++; if (wb_src !== 3'd0) begin tests_failed++; $display("FAIL reset_src: got %0d exp 0", wb_src); end
    tests_run++; if (wb_redirect !== 1'b0) begin tests_failed++; $display("FAIL reset_redirect: got %0b exp 0", wb_redirect); end
    tests_run++; if (wb_redirect_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_rpc: got %0h exp 0", wb_redirect_pc); end
    tests_run++; if (afull !== 5'd0) begin tests_failed++; $display("FAIL reset_afull: got %0b exp 0", afull); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b exp 0", overflow); end
    #9 rst = 1'b1;
    repeat (3) tick();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_valid: got %0b exp 0", wb_valid); end
    tests_run++; if (wb_tag !== 4'd0) begin tests_failed++; $display("FAIL idle_tag: got %0h exp 0", wb_tag); end
    tests_run++; if (afull !== 5'd0) begin tests_failed++; $display("FAIL idle_afull: got %0b exp 0", afull); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL idle_overflow: got %0b exp 0", overflow); end
  endtask

  task automatic test_single_alu();
    alu_target = 4'd3; alu_result = 32'h1234;
    tick();
    clear_inputs();
    if (LAT == 2) tick();
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL alu_valid: got %0b exp 1", wb_valid); end
    tests_run++; if (wb_tag !== 4'd3) begin tests_failed++; $display("FAIL alu_tag: got %0h exp 3", wb_tag); end
    tests_run++; if (wb_value !== 32'h1234) begin tests_failed++; $display("FAIL alu_value: got %0h exp 1234", wb_value); end
    tests_run++; if (wb_src !== 3'd0) begin tests_failed++; $display("FAIL alu_src: got %0d exp 0", wb_src); end
    tests_run++; if (wb_redirect !== 1'b0) begin tests_failed++; $display("FAIL alu_redirect: got %0b exp 0", wb_redirect); end
    tick();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL alu_after_valid: got %0b exp 0", wb_valid); end
  endtask

  task automatic test_collision();
    logic [3:0]  exp_tag [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [31:0] exp_val [5] = '{32'hA1, 32'hB2, 32'h14, 32'h0, 32'hE5};
    logic        exp_red [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_pc  [5] = '{32'h0, 32'h0, 32'h50, 32'h60, 32'h0};
    do_flush();
    alu_target = 4'd1; alu_result = 32'hA1;
    fwd_target = 4'd2; fwd_result = 32'hB2;
    jmp_target = 4'd3; jmp_ori_pc = 32'h10; jmp_next_pc = 32'h50;
    br_target  = 4'd4; br_next_pc = 32'h60; br_cmp_res = 1'b1;
    mem_target = 4'd5; mem_result = 32'hE5;
    tick();
    clear_inputs();
    if (LAT == 2) tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL coll_valid[%0d]: got %0b exp 1", i, wb_valid); end
      tests_run++; if (wb_tag !== exp_tag[i]) begin tests_failed++; $display("FAIL coll_tag[%0d]: got %0h exp %0h", i, wb_tag, exp_tag[i]); end
      tests_run++; if (wb_src !== 3'(i)) begin tests_failed++; $display("FAIL coll_src[%0d]: got %0d exp %0d", i, wb_src, i); end
      tests_run++; if (wb_value !== exp_val[i]) begin tests_failed++; $display("FAIL coll_value[%0d]: got %0h exp %0h", i, wb_value, exp_val[i]); end
      tests_run++; if (wb_redirect !== exp_red[i]) begin tests_failed++; $display("FAIL coll_redirect[%0d]: got %0b exp %0b", i, wb_redirect, exp_red[i]); end
      if (exp_red[i]) begin
        tests_run++; if (wb_redirect_pc !== exp_pc[i]) begin tests_failed++; $display("FAIL coll_rpc[%0d]: got %0h exp %0h", i, wb_redirect_pc, exp_pc[i]); end
      end
      tick();
    end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL coll_drained: got %0b exp 0", wb_valid); end
    // pointer wrapped to 0: alu must beat mem when both arrive together
    alu_target = 4'd7; alu_result = 32'h77;
    mem_target = 4'd8; mem_result = 32'h88;
    tick();
    clear_inputs();
    if (LAT == 2) tick();
    tests_run++; if (wb_tag !== 4'd7 || wb_src !== 3'd0) begin tests_failed++; $display("FAIL wrap_first: got tag %0h src %0d exp tag 7 src 0", wb_tag, wb_src); end
    tick();
    tests_run++; if (wb_tag !== 4'd8 || wb_src !== 3'd4) begin tests_failed++; $display("FAIL wrap_second: got tag %0h src %0d exp tag 8 src 4", wb_tag, wb_src); end
    repeat (2) tick();
  endtask

  task automatic test_jump_branch();
    logic [3:0]  tg [4] = '{4'd6, 4'd9, 4'd10, 4'd11};
    logic        isj [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] pa [4] = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [31:0] pb [4] = '{32'h200, 32'h300, 32'h400, 32'h40};
    logic        cmp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ev [4] = '{32'h104, 32'h0, 32'h0, 32'h0};
    logic        er [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (isj[i]) begin
        jmp_target = tg[i]; jmp_ori_pc = pa[i]; jmp_next_pc = pb[i];
      end else begin
        br_target = tg[i]; br_next_pc = pb[i]; br_cmp_res = cmp[i];
      end
      tick();
      clear_inputs();
      if (LAT == 2) tick();
      tests_run++; if (wb_valid !== 1'b1 || wb_tag !== tg[i]) begin tests_failed++; $display("FAIL jb_tag[%0d]: got v%0b tag %0h exp v1 tag %0h", i, wb_valid, wb_tag, tg[i]); end
      tests_run++; if (wb_src !== (isj[i] ? 3'd2 : 3'd3)) begin tests_failed++; $display("FAIL jb_src[%0d]: got %0d", i, wb_src); end
      tests_run++; if (wb_value !== ev[i]) begin tests_failed++; $display("FAIL jb_value[%0d]: got %0h exp %0h", i, wb_value, ev[i]); end
      tests_run++; if (wb_redirect !== er[i]) begin tests_failed++; $display("FAIL jb_redirect[%0d]: got %0b exp %0b", i, wb_redirect, er[i]); end
      if (er[i]) begin
        tests_run++; if (wb_redirect_pc !== pb[i]) begin tests_failed++; $display("FAIL jb_rpc[%0d]: got %0h exp %0h", i, wb_redirect_pc, pb[i]); end
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_overflow();
    logic [3:0] alu_seen [$];
    do_flush();
    for (int k = 0; k < 22; k++) begin
      if (wb_valid === 1'b1 && wb_src === 3'd0) alu_seen.push_back(wb_tag);
`ifndef EXWB_BYPASS_EN
      if (k == 4) begin
        tests_run++; if (afull[0] !== 1'b0) begin tests_failed++; $display("FAIL afull_below: got %0b exp 0", afull[0]); end
      end
      if (k == 5) begin
        tests_run++; if (afull !== 5'b00001) begin tests_failed++; $display("FAIL afull_rise: got %0b exp 00001", afull); end
      end
      if (k == 8) begin
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before: got %0b exp 0", overflow); end
      end
      if (k == 9) begin
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %0b exp 1", overflow); end
      end
`endif
      if (k <= 8) begin
        alu_target = 4'(k + 1); alu_result = 32'(k + 1);
        fwd_target = (k % 2 == 0) ? 4'd15 : 4'd0; fwd_result = 32'hF;
      end else begin
        clear_inputs();
      end
      tick();
    end
`ifndef EXWB_BYPASS_EN
    tests_run++; if (alu_seen.size() !== 8) begin tests_failed++; $display("FAIL ovf_alu_count: got %0d exp 8", alu_seen.size()); end
    for (int i = 0; i < alu_seen.size(); i++) begin
      tests_run++; if (alu_seen[i] !== 4'(i + 1)) begin tests_failed++; $display("FAIL ovf_order[%0d]: got %0h exp %0h", i, alu_seen[i], i + 1); end
    end
    for (int i = 0; i < alu_seen.size(); i++) begin
      tests_run++; if (alu_seen[i] === 4'd9) begin tests_failed++; $display("FAIL ovf_dropped_seen: got tag %0h exp never 9", alu_seen[i]); end
    end
`else
    for (int i = 1; i < alu_seen.size(); i++) begin
      tests_run++; if (alu_seen[i] <= alu_seen[i-1]) begin tests_failed++; $display("FAIL ovf_order[%0d]: got %0h after %0h", i, alu_seen[i], alu_seen[i-1]); end
    end
`endif
  endtask

  task automatic test_flush();
    alu_target = 4'd1; alu_result = 32'h11;
    fwd_target = 4'd2; fwd_result = 32'h22;
    mem_target = 4'd3; mem_result = 32'h33;
    tick();
    clear_inputs();
    do_flush();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %0b exp 0", wb_valid); end
    tests_run++; if (wb_redirect !== 1'b0) begin tests_failed++; $display("FAIL flush_redirect: got %0b exp 0", wb_redirect); end
    tests_run++; if (afull !== 5'd0) begin tests_failed++; $display("FAIL flush_afull: got %0b exp 0", afull); end
`ifndef EXWB_BYPASS_EN
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL flush_ovf_kept: got %0b exp 1", overflow); end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard[%0d]: got valid %0b tag %0h exp 0", i, wb_valid, wb_tag); end
    end
    alu_target = 4'd4; alu_result = 32'hABCD;
    tick();
    clear_inputs();
    if (LAT == 2) begin
      tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL post_flush_early: got %0b exp 0", wb_valid); end
      tick();
    end
    tests_run++; if (wb_valid !== 1'b1 || wb_tag !== 4'd4) begin tests_failed++; $display("FAIL post_flush_tag: got v%0b tag %0h exp v1 tag 4", wb_valid, wb_tag); end
    tests_run++; if (wb_value !== 32'hABCD) begin tests_failed++; $display("FAIL post_flush_value: got %0h exp abcd", wb_value); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_jump_branch();
    test_overflow();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
